store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write buffer placed between the MEM-stage access logic and the single-ported, word-wide data memory. The memory supports one access per cycle and only full-word writes.
- Accepts byte-enabled stores from the pipeline and queues them in a FIFO.
- Drains one entry per idle memory cycle as a read-modify-write, merging the enabled bytes into the current memory word.
- Serves loads with priority and forwards pending buffered bytes, so loads always see program-order data.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- AW, 12, memory word-address width, covering word address bits [13:2].

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  store request from the MEM stage
- st_addr  input  32  store byte address; bits [1:0] ignored, bits [AW+1:2] used
- st_be  input  4  byte enables, bit i selects byte lane i (bits 8i+7:8i)
- st_data  input  32  store data, already lane-aligned
- st_pc  input  32  PC of the store instruction, carried with the entry
- st_ready  output  1  buffer can accept a store this cycle
- ld_valid  input  1  load request from the MEM stage
- ld_addr  input  32  load byte address; word-aligned use
- ld_data  output  32  load word with forwarding applied; combinational
- dm_a  output  AW  memory word address
- dm_wData  output  32  memory write data
- dm_wEn  output  1  memory write enable
- dm_pc  output  32  PC of the draining entry, used for the memory's write trace
- dm_v  input  32  memory combinational read data at dm_a
- sb_empty  output  1  no valid entries
- sb_count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular FIFO with head/tail pointers and a count. Each entry holds word address, be[3:0], data[31:0] and pc[31:0].
- Reset: on clk edge with reset=1, head=tail=count=0 and all entries cleared; pending stores are discarded (reset mid-drain included).
- Reset output values: while reset=1, dm_wEn=0. After reset, sb_empty=1, sb_count=0, st_ready=1.
- st_ready = (count != DEPTH). It does not look ahead at a drain in the same cycle.
- Enqueue: when st_valid && st_ready, write the entry at tail on the clk edge and advance tail. Stores with st_be=0 are accepted and then dropped: no entry is allocated.
- Port arbitration, load cycle (ld_valid=1):
  - dm_a = ld_addr[AW+1:2], dm_wEn=0; no drain this cycle.
- Port arbitration, drain cycle (ld_valid=0 and count>0):
  - dm_a = head address, dm_pc = head pc, dm_wEn=1.
  - dm_wData: per byte lane, head data where be is set, otherwise dm_v.
  - Head advances on the clk edge.
- Port arbitration, idle (ld_valid=0 and count=0): dm_wEn=0, dm_a = 0.
- Forwarding: ld_data starts from dm_v. Every valid entry whose address matches ld_addr's word is overlaid in order, oldest to youngest, byte lane by byte lane, so the youngest write wins per byte. Fully combinational; zero-cycle load latency.
- A store accepted in cycle N is visible to loads from cycle N+1.
- If st_valid and ld_valid are asserted in the same cycle, both are serviced and the store is not forwarded to that load. The pipeline issues at most one MEM op per cycle, so this case is a don't-care for ordering.
- Count update: +1 on enqueue only, −1 on drain only, unchanged when both or neither occur. Pointers wrap modulo DEPTH.
- Full with drain: st_ready=0 that cycle. The stall lifts the next cycle.
- Empty: sb_empty=1 and no memory write is issued.
- Store latency to memory: at least 1 cycle after acceptance, extended by 1 cycle per load and per older entry.

Optional Feature:
SB_COALESCE_EN
- Defined: an incoming store whose word address equals the youngest valid entry (tail−1), where that entry is not being drained this cycle, merges into that entry instead of allocating.
  - be becomes old_be | st_be.
  - Enabled lanes take st_data.
  - pc takes st_pc.
  - Merging is allowed when count=DEPTH, so st_ready=1 in that case.
- Undefined: every store with st_be≠0 allocates a new entry; st_ready follows the rule above.

Test Plan:
- Reset, then sw 0x1234_5678 to 0x0000_0010 with no loads → next cycle dm_wEn=1, dm_a=0x004, dm_wData=0x1234_5678, dm_pc=st_pc; the cycle after, sb_empty=1.
- Memory word 0x004 = 0xAABB_CCDD, sb to byte 0x11 (be=0001, data=0x0000_0011) → drain writes 0xAABB_CC11.
- Enqueue sh be=1100 data=0xBEEF_0000 at 0x20, then immediately hold ld_valid=1 at 0x20 for 3 cycles with memory=0 → ld_data=0xBEEF_0000 each cycle and dm_wEn=0; drain occurs after ld_valid drops.
- With DEPTH=4 and ld_valid held high, issue 5 stores to distinct words → st_ready=0 after the fourth and sb_count=4; release the load → one entry drains per cycle, in FIFO order.
- Two stores to 0x30 (be=1111 data=0x1111_1111, then be=0011 data=0x0000_2222) → load 0x30 returns 0x1111_2222. With SB_COALESCE_EN, sb_count=1; without it, sb_count=2.
- Assert reset with 3 entries pending → sb_count=0, dm_wEn=0, and none of the 3 stores reach memory.

Source files
------------

// File: rtl/store_buffer.sv
// ============================================================================
//  Module      : store_buffer
//  Description : Byte-enabled store FIFO that sits in front of a single-ported,
//                word-wide data memory. Loads own the memory port and see
//                buffered bytes by forwarding. Idle memory cycles drain the
//                oldest entry as a read-modify-write.
//                Optional build macro SB_COALESCE_EN: a store to the same word
//                as the youngest entry merges into it instead of allocating.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [3:0]                 st_be,
    input  logic [31:0]                st_data,
    input  logic [31:0]                st_pc,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic [31:0]                ld_data,
    output logic [AW-1:0]              dm_a,
    output logic [31:0]                dm_wData,
    output logic                       dm_wEn,
    output logic [31:0]                dm_pc,
    input  logic [31:0]                dm_v,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage
    logic [AW-1:0] addr_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] w_st_word;
    logic [AW-1:0] w_ld_word;
    logic          w_drain;
    logic          w_merge;
    logic          w_accept;
    logic          w_alloc;
    logic          w_merge_wr;
    logic          w_unused;

    assign w_st_word = st_addr[AW+1:2];
    assign w_ld_word = ld_addr[AW+1:2];
    assign w_unused  = ^{st_addr[31:AW+2], st_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

    // Loads own the memory port; otherwise any pending entry drains.
    assign w_drain = !ld_valid && (count_q != '0);

`ifdef SB_COALESCE_EN
    logic [PW-1:0] w_young;
    assign w_young = tail_q - PW'(1);
    // The youngest entry is only the one draining when it is also the oldest.
    assign w_merge = (count_q != '0) && (addr_q[w_young] == w_st_word)
                     && !(w_drain && (count_q == CW'(1)));
`else
    assign w_merge = 1'b0;
`endif

    assign st_ready   = (count_q != CW'(DEPTH)) || w_merge;
    assign w_accept   = st_valid && st_ready && (st_be != 4'b0000);
    assign w_alloc    = w_accept && !w_merge;
    assign w_merge_wr = w_accept && w_merge;

    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_drain) head_d = head_q + PW'(1);
        if (w_alloc) tail_d = tail_q + PW'(1);
        case ({w_alloc, w_drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry writes: allocate at tail, or merge into the youngest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (w_alloc) begin
            addr_q[tail_q] <= w_st_word;
            be_q[tail_q]   <= st_be;
            data_q[tail_q] <= st_data;
            pc_q[tail_q]   <= st_pc;
        end
`ifdef SB_COALESCE_EN
        else if (w_merge_wr) begin
            be_q[w_young] <= be_q[w_young] | st_be;
            pc_q[w_young] <= st_pc;
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data_q[w_young][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
`endif
    end

    // Forwarding: overlay matching entries oldest-first so the youngest byte wins
    always_comb begin
        logic [PW-1:0] idx;
        ld_data = dm_v;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == w_ld_word)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[idx][b]) ld_data[8*b +: 8] = data_q[idx][8*b +: 8];
                end
            end
        end
    end

    // Memory port: load address, or read-modify-write of the head entry
    always_comb begin
        dm_a     = '0;
        dm_wData = '0;
        dm_wEn   = 1'b0;
        dm_pc    = '0;
        if (ld_valid) begin
            dm_a = w_ld_word;
        end else if (count_q != '0) begin
            dm_a   = addr_q[head_q];
            dm_pc  = pc_q[head_q];
            dm_wEn = !reset;
            for (int b = 0; b < 4; b++) begin
                dm_wData[8*b +: 8] = be_q[head_q][b] ? data_q[head_q][8*b +: 8]
                                                     : dm_v[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A queue-based model of
//                the buffer and its own copy of memory predict every output on
//                every cycle; directed sequences pin the model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MW    = 1 << AW;
`ifdef SB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic [AW-1:0] dm_a;
    logic [31:0]   dm_wData;
    logic          dm_wEn;
    logic [31:0]   dm_pc;
    logic [31:0]   dm_v;
    logic          sb_empty;
    logic [CW-1:0] sb_count;

    int checks   = 0;
    int failures = 0;
    logic mem_init;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_be(st_be),
        .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .dm_a(dm_a), .dm_wData(dm_wData), .dm_wEn(dm_wEn), .dm_pc(dm_pc),
        .dm_v(dm_v), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    // Environment memory driven by the DUT
    logic [31:0] env_mem [MW];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MW; i++) env_mem[i] <= 32'h0;
        end else if (dm_wEn) begin
            env_mem[dm_a] <= dm_wData;
        end
    end
    assign dm_v = env_mem[dm_a];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
        logic [31:0]   pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [MW];

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] fwd(input logic [AW-1:0] w);
        logic [31:0] v;
        v = ref_mem[w];
        foreach (q[i]) if (q[i].a == w) v = lanes(v, q[i].d, q[i].be);
        return v;
    endfunction

    function automatic bit can_merge(input logic [AW-1:0] w, input bit drn);
        if (!COAL || q.size() == 0) return 1'b0;
        if (q[q.size()-1].a != w) return 1'b0;
        return !(drn && q.size() == 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state advance on each clock edge
    always @(posedge clk) begin
        bit          drn, mrg, rdy;
        logic [AW-1:0] w;
        ent_t        e;
        if (mem_init) for (int i = 0; i < MW; i++) ref_mem[i] = 32'h0;
        if (reset) begin
            q.delete();
        end else begin
            drn = !ld_valid && q.size() > 0;
            w   = st_addr[AW+1:2];
            mrg = can_merge(w, drn);
            rdy = (q.size() != DEPTH) || mrg;
            if (drn) begin
                ref_mem[q[0].a] = lanes(ref_mem[q[0].a], q[0].d, q[0].be);
                void'(q.pop_front());
            end
            if (st_valid && rdy && st_be != 4'b0) begin
                if (mrg) begin
                    e    = q[q.size()-1];
                    e.be = e.be | st_be;
                    e.d  = lanes(e.d, st_data, st_be);
                    e.pc = st_pc;
                    q[q.size()-1] = e;
                end else begin
                    e.a = w; e.be = st_be; e.d = st_data; e.pc = st_pc;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle
    always @(negedge clk) begin
        bit drn, rdy;
        if (!mem_init) begin
            if (reset) begin
                chk("wen_in_reset", 32'(dm_wEn), 32'h0);
            end else begin
                drn = !ld_valid && q.size() > 0;
                rdy = (q.size() != DEPTH) || can_merge(st_addr[AW+1:2], drn);
                chk("st_ready", 32'(st_ready), 32'(rdy));
                chk("sb_count", 32'(sb_count), 32'(q.size()));
                chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
                chk("dm_wEn", 32'(dm_wEn), 32'(drn));
                if (ld_valid) begin
                    chk("dm_a_ld", 32'(dm_a), 32'(ld_addr[AW+1:2]));
                    chk("ld_data", ld_data, fwd(ld_addr[AW+1:2]));
                end else if (drn) begin
                    chk("dm_a_drain", 32'(dm_a), 32'(q[0].a));
                    chk("dm_wData", dm_wData, lanes(ref_mem[q[0].a], q[0].d, q[0].be));
                    chk("dm_pc", dm_pc, q[0].pc);
                end else begin
                    chk("dm_a_idle", 32'(dm_a), 32'h0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input bit v, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] pc);
        st_valid = v; st_addr = a; st_be = be; st_data = d; st_pc = pc;
    endtask

    task automatic ld(input bit v, input logic [31:0] a);
        ld_valid = v; ld_addr = a;
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        st(0, 0, 0, 0, 0); ld(0, 0);
        nxt(); nxt();
        mem_init = 1'b0;
        nxt();
        reset = 1'b0;

        // Full-word store drains the next cycle
        st(1, 32'h10, 4'hF, 32'h1234_5678, 32'h100);
        @(negedge clk);
        chk("rst_ready", 32'(st_ready), 32'h1);
        chk("rst_empty", 32'(sb_empty), 32'h1);
        chk("rst_count", 32'(sb_count), 32'h0);
        nxt();
        st(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_wen", 32'(dm_wEn), 32'h1);
        chk("t1_a", 32'(dm_a), 32'h004);
        chk("t1_wdata", dm_wData, 32'h1234_5678);
        chk("t1_pc", dm_pc, 32'h100);
        nxt();
        @(negedge clk);
        chk("t1_empty", 32'(sb_empty), 32'h1);

        // Byte store merged into existing memory word
        st(1, 32'h10, 4'hF, 32'hAABB_CCDD, 32'h104);
        nxt();
        st(1, 32'h10, 4'h1, 32'h0000_0011, 32'h108);
        nxt();
        st(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_a", 32'(dm_a), 32'h004);
        chk("t2_wdata", dm_wData, 32'hAABB_CC11);
        nxt(); nxt();

        // Loads hold off the drain and see forwarded halfword
        st(1, 32'h20, 4'hC, 32'hBEEF_0000, 32'h200);
        nxt();
        st(0, 0, 0, 0, 0);
        ld(1, 32'h20);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_ld", ld_data, 32'hBEEF_0000);
            chk("t3_nowen", 32'(dm_wEn), 32'h0);
            nxt();
        end
        ld(0, 0);
        @(negedge clk);
        chk("t3_drain_a", 32'(dm_a), 32'h008);
        chk("t3_drain_wd", dm_wData, 32'hBEEF_0000);
        nxt();

        // Fill to DEPTH under a held load, then drain in FIFO order
        ld(1, 32'h400);
        for (int k = 0; k < 5; k++) begin
            st(1, 32'h40 + 32'(4 * k), 4'hF, 32'(k + 1), 32'h300 + 32'(k));
            if (k == 4) begin
                @(negedge clk);
                chk("t4_full_rdy", 32'(st_ready), 32'h0);
                chk("t4_full_cnt", 32'(sb_count), 32'h4);
            end
            nxt();
        end
        st(0, 0, 0, 0, 0);
        ld(0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_order", 32'(dm_a), 32'h10 + 32'(k));
            nxt();
        end

        // Two stores to one word; youngest bytes win
        ld(1, 32'h30);
        st(1, 32'h30, 4'hF, 32'h1111_1111, 32'h400);
        nxt();
        st(1, 32'h30, 4'h3, 32'h0000_2222, 32'h404);
        nxt();
        st(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_ld", ld_data, 32'h1111_2222);
        chk("t5_cnt", 32'(sb_count), COAL ? 32'h1 : 32'h2);
        ld(0, 0);
        nxt(); nxt(); nxt();

        // Reset discards pending stores
        ld(1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            st(1, 32'h140 + 32'(4 * k), 4'hF, 32'hDEAD_0001 + 32'(k), 32'h500);
            nxt();
        end
        st(0, 0, 0, 0, 0);
        ld(0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_wen_rst", 32'(dm_wEn), 32'h0);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_cnt", 32'(sb_count), 32'h0);
        chk("t6_wen", 32'(dm_wEn), 32'h0);
        for (int k = 0; k < 3; k++) begin
            ld(1, 32'h140 + 32'(4 * k));
            @(negedge clk);
            chk("t6_mem", ld_data, 32'h0);
            nxt();
        end
        ld(0, 0);

        // Randomized traffic over a small address window
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            st($urandom_range(0, 1) == 1, $urandom_range(0, 31), 4'($urandom_range(0, 15)),
               $urandom, $urandom);
            ld($urandom_range(0, 9) < 4, $urandom_range(0, 31));
            nxt();
        end
        reset = 1'b0;
        st(0, 0, 0, 0, 0);
        ld(0, 0);
        for (int n = 0; n < 8; n++) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
